fifo_burst_reader: RTL and testbench

- Read-side companion to the Q_srl-based StreamingFIFO wrappers.
- Watches the FIFO occupancy `count` and pops a fixed-length burst only when a full burst is resident.
- Forwards the burst downstream through a registered AXI-Stream stage and marks the last beat with TLAST.
- A timeout flushes a partial burst so tail data cannot strand; used ahead of DMA/packetising consumers that need contiguous bursts.

---
 rtl/fifo_burst_reader_if.sv | 50 +++++
 rtl/fifo_burst_reader.sv | 176 +++++++++++++++++
 tb/tb_fifo_burst_reader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader_if
//   Groups the signals that connect the burst reader to its environment:
//   the read side of a StreamingFIFO (occupancy, data, valid, pop) and the
//   downstream AXI-Stream sink (data, valid, ready, last).
//
//   Parameters
//     WIDTH  data width in bits
//     CNT_W  width of the FIFO occupancy count
//
//   Modports
//     slave  : the burst reader itself (reads count/in0, drives in0 ready
//              and the out_* stream)
//     master : the surrounding FIFO + downstream sink (or a testbench)
// ---------------------------------------------------------------------------
interface fifo_burst_reader_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 13
);
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] in0_V_V_TDATA;
  logic             in0_V_V_TVALID;
  logic             in0_V_V_TREADY;
  logic [WIDTH-1:0] out_V_V_TDATA;
  logic             out_V_V_TVALID;
  logic             out_V_V_TREADY;
  logic             out_V_V_TLAST;

  modport slave (
    input  count,
    input  in0_V_V_TDATA,
    input  in0_V_V_TVALID,
    output in0_V_V_TREADY,
    output out_V_V_TDATA,
    output out_V_V_TVALID,
    output out_V_V_TLAST,
    input  out_V_V_TREADY
  );

  modport master (
    output count,
    output in0_V_V_TDATA,
    output in0_V_V_TVALID,
    input  in0_V_V_TREADY,
    input  out_V_V_TDATA,
    input  out_V_V_TVALID,
    input  out_V_V_TLAST,
    output out_V_V_TREADY
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//   Read-side companion to a StreamingFIFO. Waits until a full burst of
//   BURST_LEN words is resident (FIFO `count`), then pops exactly that many
//   words and forwards them through a registered AXI-Stream stage, marking
//   the final beat with TLAST. If a partial burst sits idle for TIMEOUT
//   cycles it is flushed as a shorter burst so tail data cannot strand.
//
//   Parameters
//     WIDTH      data width in bits
//     CNT_W      width of the FIFO count input
//     BURST_LEN  beats per full burst (1 .. 2^CNT_W-1)
//     TIMEOUT    idle cycles with 0 < count < BURST_LEN before a flush;
//                0 disables flushing
//
//   Ports
//     ap_clk     clock, rising edge
//     ap_rst_n   asynchronous active-low reset
//     bus        fifo_burst_reader_if.slave: count, in0_V_V_* (FIFO read
//                side, TREADY is the pop), out_V_V_* (registered stream)
//     burst_cnt  (stats build only) accepted TLAST beats of full bursts
//     flush_cnt  (stats build only) accepted TLAST beats of flushed bursts
//
//   Optional feature macro: FIFO_BURST_READER_STATS_EN adds the saturating
//   burst_cnt / flush_cnt outputs. Without it the block is otherwise
//   identical.
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 13,
  parameter int BURST_LEN = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  fifo_burst_reader_if.slave bus
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]        burst_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  // A zero-width timer is illegal, so keep one bit when flushing is off.
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST    = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beats_left;
  logic [TMR_W-1:0] timer;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             in0_ready;

  logic full_avail;
  logic part_avail;
  logic timer_hit;
  logic start_full;
  logic start_flush;
  logic pop;
  logic out_accept;
  logic last_accept;

  // count is only trusted in IDLE; these terms are gated by state below.
  assign full_avail  = (bus.count >= BURST_LEN_C);
  assign part_avail  = (TIMEOUT > 0) && (bus.count != '0);
  assign timer_hit   = part_avail && (timer == TMR_LAST);
  // A full burst wins over a timeout expiring in the same cycle.
  assign start_full  = (state == IDLE) && full_avail;
  assign start_flush = (state == IDLE) && !full_avail && timer_hit;
  assign pop         = bus.in0_V_V_TVALID && in0_ready;
  assign out_accept  = out_valid && bus.out_V_V_TREADY;
  assign last_accept = (state == RUN) && out_accept && out_last;

  assign bus.in0_V_V_TREADY = in0_ready;
  assign bus.out_V_V_TDATA  = out_data;
  assign bus.out_V_V_TVALID = out_valid;
  assign bus.out_V_V_TLAST  = out_last;

  // ---------------------------------------------------------------- FSM ---
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the signal
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start_full || start_flush) state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop only while beats remain and the output register is free or being
  // drained this cycle; this gives 1 beat/cycle with no bubble.
  always_comb begin
    in0_ready = 1'b0;
    if (state == RUN) in0_ready = (beats_left != '0) && (!out_valid || bus.out_V_V_TREADY);
  end

  // ------------------------------------------------------ idle timer ---
  // Counts consecutive IDLE cycles holding a partial burst. It stops at
  // TMR_LAST because that is the cycle the flush starts and clears it.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      timer <= '0;
    end else if ((state == IDLE) && part_avail && !full_avail && !timer_hit) begin
      timer <= timer + TMR_W'(1);
    end else begin
      timer <= '0;
    end
  end

  // ------------------------------------------ burst length / output stage ---
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      beats_left <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      if (start_full)       beats_left <= BURST_LEN_C;
      else if (start_flush) beats_left <= bus.count;
      else if (pop)         beats_left <= beats_left - CNT_W'(1);

      if (pop) begin
        out_data  <= bus.in0_V_V_TDATA;
        out_valid <= 1'b1;
        out_last  <= (beats_left == CNT_W'(1));
      end else if (out_accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef FIFO_BURST_READER_STATS_EN
  // ------------------------------------------------------------ stats ---
  logic burst_is_flush;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      burst_is_flush <= 1'b0;
      burst_cnt      <= '0;
      flush_cnt      <= '0;
    end else begin
      if (start_full)       burst_is_flush <= 1'b0;
      else if (start_flush) burst_is_flush <= 1'b1;

      if (last_accept) begin
        if (burst_is_flush) begin
          if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end else begin
          if (burst_cnt != '1) burst_cnt <= burst_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//   Bench for fifo_burst_reader (BURST_LEN=4, TIMEOUT=8) plus a second
//   instance with TIMEOUT=0 that holds count=BURST_LEN-1 for the whole run.
//   The FIFO is a queue inside the bench; the expected output stream is
//   derived from the FIFO contents by splitting them into BURST_LEN-word
//   bursts and one trailing flush.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;
  localparam int WIDTH = 8;
  localparam int CNT_W = 5;
  localparam int BL    = 4;
  localparam int TO    = 8;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    logic             flush;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               cyc;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;

  int n_pass      = 0;
  int n_total     = 0;
  int cyc         = 0;
  int model_full  = 0;
  int model_flush = 0;

  logic [WIDTH-1:0] fifo_q[$];
  exp_t             exp_q[$];
  beat_t            log_q[$];

  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;

  always #5 clk = ~clk;

  fifo_burst_reader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  fifo_burst_reader_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus_nt ();

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] burst_cnt, flush_cnt, burst_cnt_nt, flush_cnt_nt;
`endif

  fifo_burst_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_LEN(BL), .TIMEOUT(TO)) u_dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .burst_cnt(burst_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  fifo_burst_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURST_LEN(BL), .TIMEOUT(0)) u_dut_nt (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus_nt)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .burst_cnt(burst_cnt_nt),
    .flush_cnt(flush_cnt_nt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0d required=%0d", name, act, req);
  endtask

  task automatic drive_fifo();
    bus.count          = CNT_W'(fifo_q.size());
    bus.in0_V_V_TVALID = (fifo_q.size() > 0);
    bus.in0_V_V_TDATA  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  endtask

  task automatic push_words(input int start, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(WIDTH'(start + i));
    drive_fifo();
  endtask

  // Expected stream for the current FIFO contents: whole bursts of BL words,
  // then whatever is left as one flushed burst (only when flushing exists).
  task automatic build_exp();
    int n;
    int i;
    exp_q.delete();
    n = fifo_q.size();
    i = 0;
    while (n - i >= BL) begin
      for (int j = 0; j < BL; j++) exp_q.push_back('{fifo_q[i+j], (j == BL - 1), 1'b0});
      i += BL;
    end
    if (TO > 0 && n > i)
      for (int j = 0; j < n - i; j++) exp_q.push_back('{fifo_q[i+j], (j == n - i - 1), 1'b1});
  endtask

  // Per-cycle comparison of both DUTs against the reference stream.
  task automatic compare();
    exp_t e;
    if (!rst_n) begin
      check("rst tvalid", 32'(bus.out_V_V_TVALID), 0);
      check("rst tlast", 32'(bus.out_V_V_TLAST), 0);
      check("rst tdata", 32'(bus.out_V_V_TDATA), 0);
      check("rst in0 tready", 32'(bus.in0_V_V_TREADY), 0);
`ifdef FIFO_BURST_READER_STATS_EN
      check("rst burst_cnt", burst_cnt, 0);
      check("rst flush_cnt", flush_cnt, 0);
`endif
      model_full  = 0;
      model_flush = 0;
      prev_stall  = 1'b0;
      return;
    end
    check("nt in0 tready", 32'(bus_nt.in0_V_V_TREADY), 0);
    check("nt tvalid", 32'(bus_nt.out_V_V_TVALID), 0);
    if (prev_stall) begin
      check("stall tvalid held", 32'(bus.out_V_V_TVALID), 1);
      check("stall tdata held", 32'(bus.out_V_V_TDATA), 32'(prev_data));
      check("stall tlast held", 32'(bus.out_V_V_TLAST), 32'(prev_last));
    end
    if (bus.out_V_V_TVALID && bus.out_V_V_TREADY) begin
      check("beat expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat tdata", 32'(bus.out_V_V_TDATA), 32'(e.data));
        check("beat tlast", 32'(bus.out_V_V_TLAST), 32'(e.last));
        if (e.last && e.flush) model_flush++;
        else if (e.last) model_full++;
      end
      log_q.push_back('{bus.out_V_V_TDATA, bus.out_V_V_TLAST, cyc});
    end
    prev_stall = bus.out_V_V_TVALID && !bus.out_V_V_TREADY;
    prev_data  = bus.out_V_V_TDATA;
    prev_last  = bus.out_V_V_TLAST;
  endtask

  // One clock: drive at the falling edge, compare 2 time units later, then
  // apply the FIFO pop that the rising edge performed.
  task automatic tick();
    logic pop_s;
    @(negedge clk);
    bus.out_V_V_TREADY = rdy;
    drive_fifo();
    #2;
    cyc++;
    compare();
    pop_s = rst_n && bus.in0_V_V_TVALID && bus.in0_V_V_TREADY;
    @(posedge clk);
    #1;
    if (pop_s) void'(fifo_q.pop_front());
    drive_fifo();
  endtask

  task automatic drain(input string name, input int budget, input bit toggle);
    int k;
    k = 0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      if (toggle) rdy = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
      tick();
    end
    check({"drain ", name}, 32'(exp_q.size()), 0);
    rdy = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int n_last;
    bus_nt.count          = CNT_W'(BL - 1);
    bus_nt.in0_V_V_TVALID = 1'b1;
    bus_nt.in0_V_V_TDATA  = 8'h5A;
    bus_nt.out_V_V_TREADY = 1'b1;
    bus.out_V_V_TREADY    = 1'b1;

    // ---- reset, then 10 words: bursts 0-3, 4-7, flush 8-9 ----
    push_words(0, 10);
    repeat (3) tick();
    build_exp();
    log_q.delete();
    #1 rst_n = 1'b1;
    drain("ten words", 100, 1'b0);
    check("A beat count", 32'(log_q.size()), 10);
    if (log_q.size() == 10) begin
      n_last = 0;
      foreach (log_q[i]) if (log_q[i].last) n_last++;
      check("A tlast total", 32'(n_last), 3);
      check("A word3 last", 32'(log_q[3].last), 1);
      check("A word7 last", 32'(log_q[7].last), 1);
      check("A word9 data", 32'(log_q[9].data), 9);
      check("A word9 last", 32'(log_q[9].last), 1);
      // Word 7 accepted at n: GAP n+1, IDLE entry n+2, flush starts after
      // TO idle cycles (n+2+TO), pop -> word 8 at n+3+TO, word 9 at n+4+TO.
      check("A flush timing", 32'(log_q[9].cyc - log_q[7].cyc), 32'(TO + 4));
    end
`ifdef FIFO_BURST_READER_STATS_EN
    check("A burst_cnt", burst_cnt, 2);
    check("A flush_cnt", flush_cnt, 1);
`endif

    // ---- 4-beat burst with downstream ready 1,0,0,1,... ----
    log_q.delete();
    push_words(20, 4);
    build_exp();
    drain("toggle", 100, 1'b1);
    check("C beat count", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      check("C first data", 32'(log_q[0].data), 20);
      check("C word2 not last", 32'(log_q[2].last), 0);
      check("C word3 last", 32'(log_q[3].last), 1);
    end

    // ---- 8 words, continuous ready: 4 beats, GAP/IDLE turnaround, 4 beats ----
    log_q.delete();
    push_words(60, 8);
    build_exp();
    drain("back to back", 100, 1'b0);
    check("D beat count", 32'(log_q.size()), 8);
    if (log_q.size() == 8) begin
      check("D burst1 contiguous", 32'(log_q[3].cyc - log_q[0].cyc), 3);
      // last accept n -> GAP n+1 -> IDLE n+2 -> RUN pop n+3 -> beat n+4
      check("D turnaround", 32'(log_q[4].cyc - log_q[3].cyc), 4);
      check("D burst2 contiguous", 32'(log_q[7].cyc - log_q[4].cyc), 3);
      check("D word7 last", 32'(log_q[7].last), 1);
    end

    // ---- asynchronous reset after beat 2 of a burst ----
    log_q.delete();
    push_words(40, 8);
    build_exp();
    for (int i = 0; i < 30; i++) begin
      if (log_q.size() >= 2) break;
      tick();
    end
    check("E reached beat 2", 32'(log_q.size()), 2);
    #1 rst_n = 1'b0;
    #1;
    check("E async tvalid drop", 32'(bus.out_V_V_TVALID), 0);
    check("E async tlast drop", 32'(bus.out_V_V_TLAST), 0);
    check("E fifo left", 32'(fifo_q.size()), 5);
    build_exp();
    repeat (3) tick();
    log_q.delete();
    #1 rst_n = 1'b1;
    drain("after reset", 100, 1'b0);
    check("E beat count", 32'(log_q.size()), 5);
    if (log_q.size() == 5) begin
      check("E head data", 32'(log_q[0].data), 43);
      check("E word3 data", 32'(log_q[3].data), 46);
      check("E word3 last", 32'(log_q[3].last), 1);
      check("E word4 last", 32'(log_q[4].last), 1);
    end
`ifdef FIFO_BURST_READER_STATS_EN
    check("final burst_cnt", burst_cnt, 32'(model_full));
    check("final flush_cnt", flush_cnt, 32'(model_flush));
    check("nt burst_cnt", burst_cnt_nt, 0);
    check("nt flush_cnt", flush_cnt_nt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
